// File: rtl/tr_defuzzy_pkg.sv
// Shared definitions for the sequential type-reduction / defuzzification stage:
// FSM state encoding and the constant functions that size the datapath.
package tr_defuzzy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Numerator holds sum of N_SETS products of (W+1)-bit F and PW-bit position.
    function automatic int num_w_f(input int w, input int pw, input int n_sets);
        return w + 1 + pw + clog2_f(n_sets);
    endfunction

    function automatic int den_w_f(input int w, input int n_sets);
        return w + 1 + clog2_f(n_sets);
    endfunction

endpackage

// File: rtl/tr_div_serial.sv
// Serial restoring divider: load latches num/den, each step retires one
// quotient bit MSB first; done flags the step that completes the quotient.
module tr_div_serial
    import tr_defuzzy_pkg::*;
#(
    parameter int NUM_W = 19,
    parameter int DEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN_SCLK,
    input  logic             load,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic             step,
    output logic [NUM_W-1:0] quo,
    output logic             done
);

    localparam int CNT_W = (clog2_f(NUM_W + 1) > 0) ? clog2_f(NUM_W + 1) : 1;

    logic [NUM_W-1:0] q_q, q_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] dv_q, dv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   diff;
    logic [DEN_W-1:0] rem_nxt;

    always_comb begin
        // Remainder stays below the divisor, so a borrow in the MSB means "restore".
        shifted = {rem_q, q_q[NUM_W-1]};
        diff    = shifted - {1'b0, dv_q};
        quo     = {q_q[NUM_W-2:0], ~diff[DEN_W]};
        rem_nxt = diff[DEN_W] ? shifted[DEN_W-1:0] : diff[DEN_W-1:0];
        done    = step && (cnt_q == CNT_W'(NUM_W - 1));

        q_d   = q_q;
        rem_d = rem_q;
        dv_d  = dv_q;
        cnt_d = cnt_q;
        if (load) begin
            q_d   = num;
            rem_d = '0;
            dv_d  = den;
            cnt_d = '0;
        end else if (step) begin
            q_d   = quo;
            rem_d = rem_nxt;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            rem_q <= '0;
            dv_q  <= '0;
            cnt_q <= '0;
        end else if (EN_SCLK) begin
            q_q   <= q_d;
            rem_q <= rem_d;
            dv_q  <= dv_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tr_defuzzy_seq.sv
// Interval type-2 type reduction: accumulates sum(F_i*pos_i) and sum(F_i) one
// set per enabled edge, then divides serially to produce the centroid on saida.
module tr_defuzzy_seq
    import tr_defuzzy_pkg::*;
#(
    parameter int N_SETS = 3,
    parameter int W      = 8,
    parameter int PW     = 8,
    parameter int OUT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN_SCLK,
    input  logic                 start,
    input  logic [N_SETS*W-1:0]  FOU_UP,
    input  logic [N_SETS*W-1:0]  FOU_LOW,
    input  logic [N_SETS*PW-1:0] POS,
    output logic                 busy,
    output logic                 valid,
    output logic                 div_zero,
    output logic [OUT_W-1:0]     saida
);

    localparam int NUM_W = num_w_f(W, PW, N_SETS);
    localparam int DEN_W = den_w_f(W, N_SETS);
    localparam int IDX_W = (clog2_f(N_SETS) > 0) ? clog2_f(N_SETS) : 1;
    localparam int FW    = W + 1;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_SETS*W-1:0]   up_q, up_d;
    logic [N_SETS*W-1:0]   low_q, low_d;
    logic [N_SETS*PW-1:0]  pos_q, pos_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [DEN_W-1:0]      den_q, den_d;
    logic [OUT_W-1:0]      saida_q, saida_d;
    logic                  div_zero_q, div_zero_d;

    logic [FW-1:0]         f_cur;
    logic [PW-1:0]         pos_sel;
    logic [NUM_W-1:0]      num_acc;
    logic [DEN_W-1:0]      den_acc;
    logic                  accept;
    logic                  div_load;
    logic                  div_step;
    logic [NUM_W-1:0]      div_quo;
    logic                  div_done;

    function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] v);
        if ((v >> OUT_W) != '0) return '1;
        return OUT_W'(v);
    endfunction

    tr_div_serial #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .EN_SCLK (EN_SCLK),
        .load    (div_load),
        .num     (num_acc),
        .den     (den_acc),
        .step    (div_step),
        .quo     (div_quo),
        .done    (div_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        up_d       = up_q;
        low_d      = low_q;
        pos_d      = pos_q;
        num_d      = num_q;
        den_d      = den_q;
        saida_d    = saida_q;
        div_zero_d = div_zero_q;
        div_load   = 1'b0;
        div_step   = 1'b0;

        f_cur   = FW'(up_q[int'(idx_q)*W +: W]) + FW'(low_q[int'(idx_q)*W +: W]);
        pos_sel = pos_q[int'(idx_q)*PW +: PW];
        num_acc = num_q + NUM_W'(f_cur) * NUM_W'(pos_sel);
        den_acc = den_q + DEN_W'(f_cur);
        accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_ACC: begin
                num_d = num_acc;
                den_d = den_acc;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_SETS - 1)) begin
                    idx_d = '0;
                    // Empty firing strength: keep the last centroid and flag it.
                    if (den_acc == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        div_load = 1'b1;
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (div_done) begin
                    saida_d = sat_out(div_quo);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                div_zero_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Snapshot lets the caller change inputs as soon as the request is taken.
        if (accept) begin
            up_d       = FOU_UP;
            low_d      = FOU_LOW;
            pos_d      = POS;
            num_d      = '0;
            den_d      = '0;
            idx_d      = '0;
            div_zero_d = 1'b0;
            state_d    = ST_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            up_q       <= '0;
            low_q      <= '0;
            pos_q      <= '0;
            num_q      <= '0;
            den_q      <= '0;
            saida_q    <= '0;
            div_zero_q <= 1'b0;
        end else if (EN_SCLK) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            up_q       <= up_d;
            low_q      <= low_d;
            pos_q      <= pos_d;
            num_q      <= num_d;
            den_q      <= den_d;
            saida_q    <= saida_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == ST_ACC) || (state_q == ST_DIV);
    assign valid    = (state_q == ST_DONE);
    assign div_zero = div_zero_q;
    assign saida    = saida_q;

endmodule

// File: tb/tb_tr_defuzzy_seq.sv
// Scoreboard bench for tr_defuzzy_seq: a centroid model predicts each result
// and its enabled-edge latency; a monitor checks outputs on every clock.
module tb_tr_defuzzy_seq;

    localparam int N_SETS = 3;
    localparam int W      = 8;
    localparam int PW     = 8;
    localparam int OUT_W  = 8;
    localparam int NUM_W  = W + 1 + PW + $clog2(N_SETS);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 EN_SCLK;
    logic                 start;
    logic [N_SETS*W-1:0]  FOU_UP;
    logic [N_SETS*W-1:0]  FOU_LOW;
    logic [N_SETS*PW-1:0] POS;
    logic                 busy;
    logic                 valid;
    logic                 div_zero;
    logic [OUT_W-1:0]     saida;

    tr_defuzzy_seq #(
        .N_SETS (N_SETS),
        .W      (W),
        .PW     (PW),
        .OUT_W  (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .EN_SCLK  (EN_SCLK),
        .start    (start),
        .FOU_UP   (FOU_UP),
        .FOU_LOW  (FOU_LOW),
        .POS      (POS),
        .busy     (busy),
        .valid    (valid),
        .div_zero (div_zero),
        .saida    (saida)
    );

    always #5 clk = ~clk;

    typedef struct {
        int saida;
        bit dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   en_toggle = 1'b0;

    // model state: 0 idle, 1 working, 2 result presented
    int   m_state = 0;
    int   m_cnt   = 0;
    bit   m_dz    = 1'b0;
    int   m_last  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [N_SETS*W-1:0] u,
                                       input logic [N_SETS*W-1:0] l,
                                       input logic [N_SETS*PW-1:0] p,
                                       input int last);
        longint num, den, q;
        exp_t   e;
        num = 0;
        den = 0;
        for (int i = 0; i < N_SETS; i++) begin
            longint f;
            f = longint'(u[i*W +: W]) + longint'(l[i*W +: W]);
            num += f * longint'(p[i*PW +: PW]);
            den += f;
        end
        if (den == 0) begin
            e.saida = last;
            e.dz    = 1'b1;
        end else begin
            q = num / den;
            if (q > (1 << OUT_W) - 1) q = (1 << OUT_W) - 1;
            e.saida = int'(q);
            e.dz    = 1'b0;
        end
        return e;
    endfunction

    // Reference: accept on an enabled edge when not working, then count
    // enabled edges down to the result.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_state = 0;
            m_last  = 0;
            m_dz    = 1'b0;
            exp_q.delete();
        end else if (EN_SCLK) begin
            if (m_state == 1) begin
                m_cnt--;
                if (m_cnt == 0) m_state = 2;
            end else if (start) begin
                exp_t e;
                e = ref_model(FOU_UP, FOU_LOW, POS, m_last);
                if (!e.dz) m_last = e.saida;
                exp_q.push_back(e);
                m_dz    = e.dz;
                m_cnt   = e.dz ? N_SETS : N_SETS + NUM_W;
                m_state = 1;
            end else begin
                m_state = 0;
            end
        end
    end

    // Monitor
    bit prev_v    = 1'b0;
    int exp_saida = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_v    = 1'b0;
            exp_saida = 0;
        end else begin
            if (valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got saida %0d, expected no result at %0t", saida, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_saida", saida, e.saida);
                    chk("result_div_zero", div_zero, e.dz);
                    exp_saida = e.saida;
                end
            end
            chk("busy", busy, m_state == 1);
            chk("valid", valid, m_state == 2);
            chk("div_zero", div_zero, (m_state == 2) && m_dz);
            chk("saida_hold", saida, exp_saida);
            prev_v = valid;
        end
    end

    task automatic step();
        @(negedge clk);
        EN_SCLK = en_toggle ? ~EN_SCLK : 1'b1;
    endtask

    task automatic scramble();
        FOU_UP  = (N_SETS*W)'($urandom);
        FOU_LOW = (N_SETS*W)'($urandom);
        POS     = (N_SETS*PW)'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        step();
        while (busy && k < 400) begin
            step();
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: got busy=1, expected 0 at %0t", $time);
        end
    endtask

    task automatic issue(input logic [N_SETS*W-1:0] u,
                         input logic [N_SETS*W-1:0] l,
                         input logic [N_SETS*PW-1:0] p);
        wait_idle();
        do step(); while (!EN_SCLK);
        FOU_UP  = u;
        FOU_LOW = l;
        POS     = p;
        start   = 1'b1;
        step();
        start   = 1'b0;
        scramble();
    endtask

    task automatic directed_set();
        issue({8'd0, 8'd0, 8'd100}, {8'd0, 8'd0, 8'd100}, {8'd255, 8'd128, 8'd50});
        issue({8'd0, 8'd100, 8'd100}, {8'd0, 8'd100, 8'd100}, {8'd255, 8'd128, 8'd0});
        issue('0, '0, {8'd10, 8'd20, 8'd30});
        wait_idle();
        repeat (3) step();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no end of test, expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        EN_SCLK = 1'b1;
        start   = 1'b0;
        FOU_UP  = '0;
        FOU_LOW = '0;
        POS     = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_div_zero", div_zero, 0);
        chk("reset_saida", saida, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        en_toggle = 1'b0;
        directed_set();
        en_toggle = 1'b1;
        directed_set();
        en_toggle = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [N_SETS*W-1:0] u, l;
            en_toggle = ($urandom_range(0, 3) == 0);
            u = (N_SETS*W)'($urandom);
            l = (N_SETS*W)'($urandom);
            if (i % 5 == 4) begin
                u = '0;
                l = '0;
            end
            issue(u, l, (N_SETS*PW)'($urandom));
        end
        wait_idle();
        en_toggle = 1'b0;

        // Requests while busy are dropped.
        issue((N_SETS*W)'($urandom), (N_SETS*W)'($urandom), (N_SETS*PW)'($urandom));
        for (int k = 0; k < 16; k++) begin
            start = (k == 2 || k == 7 || k == 13);
            step();
        end
        start = 1'b0;
        wait_idle();

        // start held high: back-to-back results with fresh snapshots.
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            scramble();
            step();
        end
        start = 1'b0;
        wait_idle();
        repeat (3) step();

        // Reset in the middle of a division.
        issue({8'd0, 8'd100, 8'd100}, {8'd0, 8'd100, 8'd100}, {8'd255, 8'd128, 8'd0});
        repeat (8) step();
        chk("mid_div_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_saida", saida, 0);
        chk("abort_div_zero", div_zero, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("no_result_after_abort", valid, 0);

        // Zero denominator after reset keeps the reset value of saida.
        issue('0, '0, (N_SETS*PW)'($urandom));
        wait_idle();
        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
